// File: rtl/chan_sel_mux.sv
// chan_sel_mux: registered N-channel selector with DIRECT, SCAN (round-robin
// with programmable dwell) and HOLD modes. All outputs come from flops.
// Channel k of din occupies din[k*WIDTH +: WIDTH].
//
// Handshake: dout_valid is a one-cycle qualifier with no back-pressure. It is
// high for exactly the cycles in which dout was loaded with fresh channel data
// (DIRECT with an in-range select, or any SCAN cycle). It is low otherwise.
module chan_sel_mux #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 1,
  parameter int SEL_W    = 2,
  parameter int DWELL_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [DWELL_W-1:0]        dwell,
  input  logic [CHANNELS*WIDTH-1:0] din,
  output logic [WIDTH-1:0]          dout,
  output logic                      dout_valid,
  output logic [SEL_W-1:0]          cur_chan,
  output logic                      scan_wrap,
  output logic                      sel_err
);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_SCAN   = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  // Channel count widened by one bit so it can be compared against sel.
  localparam logic [SEL_W:0]   CH_CNT  = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS-1);

  // Registered state
  logic [WIDTH-1:0]   r_dout;
  logic               r_valid;
  logic [SEL_W-1:0]   r_chan;       // doubles as the scan pointer
  logic               r_wrap;
  logic               r_err;
  logic [DWELL_W-1:0] r_cnt;
  mode_e              r_last_mode;

  // Next-state values
  logic [WIDTH-1:0]   w_dout_nxt;
  logic               w_valid_nxt;
  logic [SEL_W-1:0]   w_chan_nxt;
  logic               w_wrap_nxt;
  logic               w_err_nxt;
  logic [DWELL_W-1:0] w_cnt_nxt;
  mode_e              w_last_nxt;

  // Scan datapath
  mode_e              w_mode;
  logic               w_sel_ok;
  logic               w_scan_entry;
  logic [SEL_W-1:0]   w_ptr;
  logic [DWELL_W-1:0] w_scan_cnt;
  logic               w_wrap_adv;
  logic [WIDTH-1:0]   w_sel_data;
  logic [WIDTH-1:0]   w_ptr_data;

  // Out-of-range indices return zero rather than reading past the bus.
  function automatic logic [WIDTH-1:0] chan_data(
    input logic [CHANNELS*WIDTH-1:0] bus,
    input logic [SEL_W-1:0]          idx
  );
    logic [WIDTH-1:0] data;
    data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == SEL_W'(k)) data = bus[k*WIDTH +: WIDTH];
    end
    return data;
  endfunction

  assign w_mode       = mode_e'(mode);
  assign w_sel_ok     = ({1'b0, sel} < CH_CNT);
  assign w_scan_entry = (r_last_mode != MODE_SCAN);
  assign w_sel_data   = chan_data(din, sel);
  assign w_ptr_data   = chan_data(din, w_ptr);

  // Scan pointer / dwell counter: restart on entry, else count and advance.
  always_comb begin
    w_ptr      = r_chan;
    w_scan_cnt = r_cnt;
    w_wrap_adv = 1'b0;
    if (w_scan_entry) begin
      w_ptr      = w_sel_ok ? sel : '0;
      w_scan_cnt = '0;
    end else if (r_cnt == dwell) begin
      w_scan_cnt = '0;
      if (r_chan == LAST_CH) begin
        w_ptr      = '0;
        w_wrap_adv = 1'b1;
      end else begin
        w_ptr = r_chan + SEL_W'(1);
      end
    end else begin
      // Free-running wrap lets a shrunken dwell be caught on the next lap.
      w_scan_cnt = r_cnt + DWELL_W'(1);
    end
  end

  // Mode decode: next values for every register; defaults hold state.
  always_comb begin
    w_dout_nxt  = r_dout;
    w_valid_nxt = 1'b0;
    w_chan_nxt  = r_chan;
    w_wrap_nxt  = 1'b0;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last_mode;
    if (en) begin
      w_last_nxt = w_mode;
      case (w_mode)
        MODE_DIRECT: begin
          if (w_sel_ok) begin
            w_dout_nxt  = w_sel_data;
            w_chan_nxt  = sel;
            w_valid_nxt = 1'b1;
          end else begin
            w_dout_nxt = '0;
            w_err_nxt  = 1'b1;
          end
        end
        MODE_SCAN: begin
          w_dout_nxt  = w_ptr_data;
          w_chan_nxt  = w_ptr;
          w_valid_nxt = 1'b1;
          w_wrap_nxt  = w_wrap_adv;
          w_cnt_nxt   = w_scan_cnt;
        end
        default: begin
          // HOLD and reserved: freeze data, pointer and counter.
        end
      endcase
    end
  end

  // State register with synchronous reset; reset wins over en and mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout      <= '0;
      r_valid     <= 1'b0;
      r_chan      <= '0;
      r_wrap      <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_last_mode <= MODE_HOLD;
    end else begin
      r_dout      <= w_dout_nxt;
      r_valid     <= w_valid_nxt;
      r_chan      <= w_chan_nxt;
      r_wrap      <= w_wrap_nxt;
      r_err       <= w_err_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last_mode <= w_last_nxt;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign cur_chan   = r_chan;
  assign scan_wrap  = r_wrap;
  assign sel_err    = r_err;

endmodule

// File: tb/tb_chan_sel_mux.sv
// Bench for chan_sel_mux: a 4-channel and a 3-channel instance (WIDTH=8) share
// control inputs; a cycle-level behavioural model predicts both.
module tb_chan_sel_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [1:0]  sel;
  logic [3:0]  dwell;
  logic [31:0] din_a;
  logic [23:0] din_b;

  logic [7:0]  a_dout, b_dout;
  logic        a_valid, b_valid;
  logic [1:0]  a_chan, b_chan;
  logic        a_wrap, b_wrap;
  logic        a_err, b_err;

  int errors = 0;
  int checks = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  chan_sel_mux #(.CHANNELS(4), .WIDTH(8), .SEL_W(2), .DWELL_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .dwell(dwell),
    .din(din_a), .dout(a_dout), .dout_valid(a_valid), .cur_chan(a_chan),
    .scan_wrap(a_wrap), .sel_err(a_err)
  );

  chan_sel_mux #(.CHANNELS(3), .WIDTH(8), .SEL_W(2), .DWELL_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .dwell(dwell),
    .din(din_b), .dout(b_dout), .dout_valid(b_valid), .cur_chan(b_chan),
    .scan_wrap(b_wrap), .sel_err(b_err)
  );

  // Behavioural model state, one slot per instance
  logic [7:0] m_dout[2];
  bit         m_valid[2];
  int         m_chan[2];
  bit         m_wrap[2];
  bit         m_err[2];
  int         m_cnt[2];
  bit         m_in_scan[2];

  function automatic logic [7:0] m_data(input int d, input int k);
    if (d == 0) return din_a[k*8 +: 8];
    return din_b[k*8 +: 8];
  endfunction

  // One clock edge of the selector, straight from the mode rules.
  function automatic void model_step(input int d);
    int n;
    int s;
    n = (d == 0) ? 4 : 3;
    s = int'(sel);
    if (rst) begin
      m_dout[d] = 8'h00; m_valid[d] = 0; m_chan[d] = 0; m_wrap[d] = 0;
      m_err[d] = 0; m_cnt[d] = 0; m_in_scan[d] = 0;
    end else if (!en) begin
      m_valid[d] = 0; m_wrap[d] = 0;
    end else if (mode == 2'b00) begin
      m_wrap[d] = 0; m_in_scan[d] = 0;
      if (s < n) begin
        m_dout[d] = m_data(d, s); m_chan[d] = s; m_valid[d] = 1;
      end else begin
        m_dout[d] = 8'h00; m_valid[d] = 0; m_err[d] = 1;
      end
    end else if (mode == 2'b01) begin
      m_wrap[d] = 0; m_valid[d] = 1;
      if (!m_in_scan[d]) begin
        m_chan[d] = (s < n) ? s : 0;
        m_cnt[d]  = 0;
      end else if (m_cnt[d] == int'(dwell)) begin
        m_cnt[d]  = 0;
        m_wrap[d] = (m_chan[d] == n - 1);
        m_chan[d] = (m_chan[d] + 1) % n;
      end else begin
        m_cnt[d] = (m_cnt[d] + 1) % 16;
      end
      m_dout[d] = m_data(d, m_chan[d]);
      m_in_scan[d] = 1;
    end else begin
      m_valid[d] = 0; m_wrap[d] = 0; m_in_scan[d] = 0;
    end
  endfunction

  function automatic logic [12:0] obs(input int d);
    if (d == 0) return {a_dout, a_valid, a_chan, a_wrap, a_err};
    return {b_dout, b_valid, b_chan, b_wrap, b_err};
  endfunction

  function automatic logic [12:0] expv(input int d);
    return {m_dout[d], m_valid[d], 2'(m_chan[d]), m_wrap[d], m_err[d]};
  endfunction

  // Driver: one clock edge; model updates at the edge, outputs read 1ns later.
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 2'b01; sel = 2'd0; dwell = 4'd0;
    din_a = '1; din_b = '1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({a_dout, a_valid, a_chan, a_wrap, a_err} !== 13'h0) begin
        errors++;
        $display("FAIL reset_a got=%h exp=0", {a_dout, a_valid, a_chan, a_wrap, a_err});
      end
      checks++;
      if ({b_dout, b_valid, b_chan, b_wrap, b_err} !== 13'h0) begin
        errors++;
        $display("FAIL reset_b got=%h exp=0", {b_dout, b_valid, b_chan, b_wrap, b_err});
      end
    end
    rst = 1'b0; sel = 2'd2;
    tick();
    checks++;
    if (a_chan !== 2'd2 || a_valid !== 1'b1 || a_dout !== 8'hFF) begin
      errors++;
      $display("FAIL scan_after_reset chan=%0d valid=%b dout=%h exp chan=2 valid=1 dout=ff",
               a_chan, a_valid, a_dout);
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs(d) !== expv(d)) begin
        errors++;
        $display("FAIL model_reset dut%0d got=%h exp=%h", d, obs(d), expv(d));
      end
    end
  endtask

  task automatic test_direct();
    logic [7:0] exp_dout[4];
    exp_dout = '{8'h00, 8'h00, 8'h01, 8'h00};
    mode = 2'b00;
    din_a = {8'h00, 8'h01, 8'h00, 8'h00};
    din_b = 24'h5A_A5_3C;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      tick();
      checks++;
      if (a_dout !== exp_dout[i] || a_valid !== 1'b1 || a_chan !== 2'(i)) begin
        errors++;
        $display("FAIL direct_sel%0d dout=%h valid=%b chan=%0d exp dout=%h valid=1 chan=%0d",
                 i, a_dout, a_valid, a_chan, exp_dout[i], i);
      end
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs(d) !== expv(d)) begin
          errors++;
          $display("FAIL model_direct dut%0d got=%h exp=%h", d, obs(d), expv(d));
        end
      end
    end
  endtask

  task automatic test_scan_dwell2();
    int exp_chan[13];
    exp_chan = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    din_a = {8'h33, 8'h22, 8'h11, 8'h00};
    din_b = 24'hC2_B1_A0;
    sel = 2'd0; dwell = 4'd2; mode = 2'b01;
    for (int i = 0; i < 13; i++) begin
      tick();
      checks++;
      if (a_chan !== 2'(exp_chan[i]) || a_wrap !== (i == 12) ||
          a_dout !== 8'(exp_chan[i] * 8'h11)) begin
        errors++;
        $display("FAIL scan_dwell2_step%0d chan=%0d wrap=%b dout=%h exp chan=%0d wrap=%b",
                 i, a_chan, a_wrap, a_dout, exp_chan[i], (i == 12));
      end
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs(d) !== expv(d)) begin
          errors++;
          $display("FAIL model_scan2 dut%0d got=%h exp=%h", d, obs(d), expv(d));
        end
      end
    end
  endtask

  task automatic test_scan_dwell0_err();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mode = 2'b01; dwell = 4'd0; sel = 2'd0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (b_chan !== 2'(i % 3) || b_wrap !== (i == 3)) begin
        errors++;
        $display("FAIL scan_dwell0_step%0d chan=%0d wrap=%b exp chan=%0d wrap=%b",
                 i, b_chan, b_wrap, i % 3, (i == 3));
      end
    end
    mode = 2'b00; sel = 2'd3;
    tick();
    checks++;
    if (b_err !== 1'b1 || b_dout !== 8'h00 || b_valid !== 1'b0) begin
      errors++;
      $display("FAIL sel_err_set err=%b dout=%h valid=%b exp err=1 dout=0 valid=0",
               b_err, b_dout, b_valid);
    end
    sel = 2'd1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (b_err !== 1'b1 || b_valid !== 1'b1 || b_chan !== 2'd1) begin
        errors++;
        $display("FAIL sel_err_sticky err=%b valid=%b chan=%0d exp err=1 valid=1 chan=1",
                 b_err, b_valid, b_chan);
      end
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs(d) !== expv(d)) begin
        errors++;
        $display("FAIL model_dwell0 dut%0d got=%h exp=%h", d, obs(d), expv(d));
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (b_err !== 1'b0) begin
      errors++;
      $display("FAIL sel_err_clear err=%b exp=0", b_err);
    end
  endtask

  task automatic test_hold_en();
    bit         found;
    logic [7:0] snap_dout;
    logic [1:0] snap_chan;
    din_a = {8'h33, 8'h22, 8'h11, 8'h00};
    mode = 2'b01; sel = 2'd0; dwell = 4'd2;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (a_chan == 2'd2) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL hold_reach_chan2 chan=%0d exp=2", a_chan);
    end
    snap_dout = a_dout; snap_chan = a_chan;
    for (int i = 0; i < 5; i++) begin
      mode = (i < 3) ? 2'b10 : 2'b11;
      din_a = $urandom;
      tick();
      checks++;
      if (a_dout !== snap_dout || a_chan !== snap_chan || a_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_freeze dout=%h chan=%0d valid=%b exp dout=%h chan=%0d valid=0",
                 a_dout, a_chan, a_valid, snap_dout, snap_chan);
      end
    end
    din_a = {8'h33, 8'h22, 8'h11, 8'h00};
    mode = 2'b01; sel = 2'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (a_chan !== ((i < 3) ? 2'd1 : 2'd2) || a_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_resume_step%0d chan=%0d valid=%b exp chan=%0d valid=1",
                 i, a_chan, a_valid, (i < 3) ? 1 : 2);
      end
    end
    snap_dout = a_dout; snap_chan = a_chan;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din_a = $urandom;
      sel = 2'($urandom_range(0, 3));
      tick();
      checks++;
      if (a_dout !== snap_dout || a_chan !== snap_chan || a_valid !== 1'b0 || a_wrap !== 1'b0) begin
        errors++;
        $display("FAIL en_low_hold dout=%h chan=%0d valid=%b wrap=%b exp dout=%h chan=%0d",
                 a_dout, a_chan, a_valid, a_wrap, snap_dout, snap_chan);
      end
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs(d) !== expv(d)) begin
          errors++;
          $display("FAIL model_en_low dut%0d got=%h exp=%h", d, obs(d), expv(d));
        end
      end
    end
    en = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 39) == 0);
      en    = ($urandom_range(0, 9) != 0);
      mode  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) :
              (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b00);
      sel   = 2'($urandom_range(0, 3));
      dwell = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      din_a = $urandom;
      din_b = 24'($urandom);
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs(d) !== expv(d)) begin
          errors++;
          $display("FAIL model_random%0d dut%0d got=%h exp=%h", i, d, obs(d), expv(d));
        end
      end
    end
    rst = 1'b0; en = 1'b1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_dout[d] = 8'h00; m_valid[d] = 0; m_chan[d] = 0; m_wrap[d] = 0;
      m_err[d] = 0; m_cnt[d] = 0; m_in_scan[d] = 0;
    end
    rst = 1'b1; en = 1'b1; mode = 2'b01; sel = 2'd0; dwell = 4'd0;
    din_a = '1; din_b = '1;
    test_reset();
    test_direct();
    test_scan_dwell2();
    test_scan_dwell0_err();
    test_hold_en();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chan_sel_mux.md
Name: chan_sel_mux

Overview:
- Registered, parametrised N-channel selector; successor to the single-bit combinational 4:1 selector in the top-level wrapper.
- Generalised in channel count and data width.
- Adds three modes: direct (host-selected), auto-scan (round-robin with programmable dwell), and hold (freeze).
- Sits between the dedicated input pins and the output pins of the top-level tile; drives uo_out and status.

Parameters:
- CHANNELS, 4, number of input channels (2..16).
- WIDTH, 1, bits per channel.
- SEL_W, 2, select width; must equal clog2(CHANNELS).
- DWELL_W, 4, width of the dwell-count input.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  clock enable; 0 = all state holds.
- mode  in  2  00 DIRECT, 01 SCAN, 10 HOLD, 11 reserved (decodes as HOLD).
- sel  in  SEL_W  channel index for DIRECT mode, and start channel on SCAN entry.
- dwell  in  DWELL_W  SCAN: cycles per channel minus 1.
- din  in  CHANNELS*WIDTH  packed channels; channel k = din[k*WIDTH +: WIDTH].
- dout  out  WIDTH  registered selected data.
- dout_valid  out  1  dout updated this cycle.
- cur_chan  out  SEL_W  channel currently driving dout.
- scan_wrap  out  1  one-cycle pulse when SCAN pointer wraps from CHANNELS-1 to 0.
- sel_err  out  1  sticky; set when DIRECT sel >= CHANNELS.

Behaviour:
- Reset (rst=1 at posedge): dout=0, dout_valid=0, cur_chan=0, scan_wrap=0, sel_err=0, dwell counter=0, last-mode register=HOLD. Reset overrides en and mode. Reset asserted mid-scan aborts the scan immediately.
- en=0: every register holds, except dout_valid and scan_wrap, which are driven to 0.
- Latency: dout reflects din sampled at the same edge it updates. One-cycle register latency from din/sel to dout.
- DIRECT (en=1, mode=00):
  - sel < CHANNELS: dout <= din[sel], cur_chan <= sel, dout_valid <= 1.
  - sel >= CHANNELS (non-power-of-2 CHANNELS): dout <= 0, cur_chan unchanged, dout_valid <= 0, sel_err <= 1.
  - sel_err clears only on rst.
- SCAN (en=1, mode=01):
  - Entry (previous mode != SCAN):
    - pointer <= sel if sel < CHANNELS, else 0;
    - dwell counter <= 0;
    - dout <= din[that pointer];
    - dout_valid <= 1.
  - Steady state: each cycle dout <= din[pointer] and dout_valid <= 1.
  - When counter == dwell: counter <= 0 and pointer advances.
    - Advance is pointer+1, or 0 if pointer == CHANNELS-1. Wrapping to 0 sets scan_wrap=1 on the cycle pointer becomes 0.
  - Otherwise counter increments.
  - dwell=0: pointer advances every cycle.
  - cur_chan always equals the pointer used for the current dout.
  - dwell changed mid-scan takes effect on the next compare. If counter > new dwell, counter continues to 2^DWELL_W-1, wraps to 0, then compares normally.
- HOLD / 11 (en=1): dout and cur_chan hold, dout_valid=0, counter and pointer hold.
  - Returning from HOLD to SCAN counts as SCAN entry: restart from sel.
- Mode change: takes effect on the edge at which the new mode is sampled. No idle cycle is inserted.
- The last-mode register updates only when en=1.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with en=1, mode=01, din all ones.
  - Required: dout=0, dout_valid=0, cur_chan=0, scan_wrap=0, sel_err=0.
  - After rst deasserts: first SCAN cycle gives cur_chan=sel.
- DIRECT:
  - Stimulus: CHANNELS=4, WIDTH=1, din=4'b0100, sel stepped 0,1,2,3 on consecutive cycles.
  - Required: dout=0,0,1,0, each one cycle after its sel; dout_valid=1 throughout.
- SCAN, dwell=2:
  - Stimulus: CHANNELS=4, WIDTH=8, din={8'h33,8'h22,8'h11,8'h00}, sel=0.
  - Required: cur_chan sequence 0,0,0,1,1,1,2,2,2,3,3,3,0.
  - scan_wrap=1 exactly on the cycle cur_chan returns to 0.
- SCAN, dwell=0, CHANNELS=3:
  - Required: cur_chan 0,1,2,0,1,2, with scan_wrap every third cycle.
  - Then switch to DIRECT with sel=3: sel_err=1, dout=0, dout_valid=0.
  - sel_err stays 1 after sel returns to 1, until rst.
- HOLD and en:
  - Stimulus: in SCAN at cur_chan=2, set mode=10 for 5 cycles, then back to 01 with sel=1.
  - Required: dout and cur_chan frozen, dout_valid=0; scan restarts at channel 1 with a full dwell.
  - Stimulus: en=0 for 3 cycles.
  - Required: all state holds; dout_valid=0, scan_wrap=0.
